// File: rtl/reg_file.sv
// -----------------------------------------------------------------------------
// reg_file -- 31 x DATA_W general-purpose register file with a post-reset
// clear sweep.
//
// After reset the block walks x1..x[CLR_LAST], writing one register to zero per
// clock. It holds busy high during the walk so the core can stall. Once the walk
// finishes the block serves two combinational read ports and one write port.
// x0 has no storage and always reads zero.
//
// Optional feature (compile-time macro REGFILE_BYPASS_EN):
//   When defined, a write issued in the current cycle is forwarded to any read
//   port addressing the same register. Without it, a read returns the stored
//   (pre-write) value until the write edge.
//
// Ports
//   clk       in   single clock, rising edge
//   nrst      in   synchronous active-low reset
//   rs1_addr  in   read port 1 register index
//   rs2_addr  in   read port 2 register index
//   rs1       out  read port 1 data (ALU operand A)
//   rs2       out  read port 2 data (ALU operand B)
//   reg_wr    in   writeback enable
//   rd_addr   in   writeback register index
//   rd_data   in   writeback data
//   busy      out  high while the clear sweep runs
// -----------------------------------------------------------------------------
module reg_file #(
    parameter int DATA_W   = 32,
    parameter int CLR_LAST = 31
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic [4:0]        rs1_addr,
    input  logic [4:0]        rs2_addr,
    output logic [DATA_W-1:0] rs1,
    output logic [DATA_W-1:0] rs2,
    input  logic              reg_wr,
    input  logic [4:0]        rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              busy
);

    localparam logic [4:0] CLR_LAST_IDX = 5'(CLR_LAST);

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t            state, state_nxt;
    logic [4:0]        clr_idx, clr_idx_nxt;
    logic              clr_en;
    logic              wr_en;

    // x0 is hardwired to zero, so storage starts at index 1.
    logic [DATA_W-1:0] regs [1:31];

    // Control state: only the FSM and sweep pointer are reset.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state   <= CLEAR;
            clr_idx <= 5'd1;
        end else begin
            state   <= state_nxt;
            clr_idx <= clr_idx_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        clr_idx_nxt = clr_idx;
        busy        = 1'b0;
        clr_en      = 1'b0;
        wr_en       = 1'b0;
        case (state)
            CLEAR: begin
                busy   = 1'b1;
                clr_en = 1'b1;
                // The pointer stops at the last index; leaving CLEAR there
                // keeps it from ever wrapping.
                if (clr_idx == CLR_LAST_IDX) begin
                    state_nxt = RUN;
                end else begin
                    clr_idx_nxt = clr_idx + 5'd1;
                end
            end
            RUN: begin
                wr_en = reg_wr && (rd_addr != 5'd0);
            end
            default: begin
                state_nxt = CLEAR;
            end
        endcase
    end

    // Register contents change only through the sweep or a writeback. Reset
    // does not clear them directly, but it suppresses any write in the same
    // cycle, so a reset in RUN discards that cycle's writeback.
    always_ff @(posedge clk) begin
        if (nrst) begin
            if (clr_en) begin
                regs[clr_idx] <= '0;
            end else if (wr_en) begin
                regs[rd_addr] <= rd_data;
            end
        end
    end

    always_comb begin
        rs1 = '0;
        rs2 = '0;
        if (state == RUN) begin
            if (rs1_addr != 5'd0) rs1 = regs[rs1_addr];
            if (rs2_addr != 5'd0) rs2 = regs[rs2_addr];
        end
`ifdef REGFILE_BYPASS_EN
        // wr_en already implies RUN and a non-zero destination.
        if (wr_en && (rs1_addr == rd_addr)) rs1 = rd_data;
        if (wr_en && (rs2_addr == rd_addr)) rs2 = rd_data;
`else
`endif
    end

endmodule

// File: tb/tb_reg_file.sv
module tb_reg_file;

    logic        clk;
    logic        nrst;
    logic [4:0]  rs1_addr, rs2_addr, rd_addr;
    logic [31:0] rs1, rs2, rd_data;
    logic        reg_wr;
    logic        busy;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference view of the register file: plain array, x0 kept at zero.
    logic [31:0] model [0:31];

    reg_file #(.DATA_W(32), .CLR_LAST(31)) dut (
        .clk      (clk),
        .nrst     (nrst),
        .rs1_addr (rs1_addr),
        .rs2_addr (rs2_addr),
        .rs1      (rs1),
        .rs2      (rs2),
        .reg_wr   (reg_wr),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected read value in RUN for the inputs currently applied.
    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
        if (reg_wr && rd_addr != 5'd0 && a == rd_addr) return rd_data;
`endif
        return model[a];
    endfunction

    // Advance one clock; the model absorbs the writeback that was applied.
    task automatic tick_run();
        @(posedge clk);
        if (nrst && reg_wr && rd_addr != 5'd0) model[rd_addr] = rd_data;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int cnt;

    initial begin
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        nrst = 1'b0; reg_wr = 1'b0; rd_addr = 5'd0; rd_data = 32'h0;
        rs1_addr = 5'd1; rs2_addr = 5'd2;

        // Reset for two cycles.
        tick(); tick();
        @(negedge clk);
        check("reset_busy", {31'h0, busy}, 32'h1);
        check("reset_rs1", rs1, 32'h0);
        check("reset_rs2", rs2, 32'h0);

        // Release, run ten sweep cycles, then pulse reset mid-sweep.
        @(posedge clk); #1;
        nrst = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        check("midsweep_busy", {31'h0, busy}, 32'h1);
        nrst = 1'b0;
        tick();
        check("pulse_busy", {31'h0, busy}, 32'h1);
        nrst = 1'b1;

        // Attempt a write during CLEAR; it must be ignored and reads stay zero.
        reg_wr = 1'b1; rd_addr = 5'd3; rd_data = 32'hA5A5A5A5;
        rs1_addr = 5'd3; rs2_addr = 5'd3;
        #1;
        check("clear_rs1", rs1, 32'h0);
        check("clear_rs2", rs2, 32'h0);
        cnt = 0;
        while (busy === 1'b1 && cnt < 100) begin
            tick();
            cnt++;
        end
        check("sweep_len", cnt, 32'd31);
        check("busy_low", {31'h0, busy}, 32'h0);
        reg_wr = 1'b0;

        // Every register reads zero after the sweep.
        for (int i = 0; i < 32; i++) begin
            rs1_addr = 5'(i); rs2_addr = 5'(31 - i);
            @(negedge clk);
            check($sformatf("swept_rs1_x%0d", i), rs1, 32'h0);
            check($sformatf("swept_rs2_x%0d", 31 - i), rs2, 32'h0);
            tick_run();
        end

        // Write x5, read both ports next cycle.
        reg_wr = 1'b1; rd_addr = 5'd5; rd_data = 32'hDEADBEEF;
        tick_run();
        reg_wr = 1'b0; rs1_addr = 5'd5; rs2_addr = 5'd5;
        @(negedge clk);
        check("x5_rs1", rs1, 32'hDEADBEEF);
        check("x5_rs2", rs2, 32'hDEADBEEF);
        tick_run();

        // Write to x0 is discarded.
        reg_wr = 1'b1; rd_addr = 5'd0; rd_data = 32'hFFFFFFFF;
        tick_run();
        reg_wr = 1'b0;
        for (int i = 0; i < 32; i++) begin
            rs1_addr = 5'(i); rs2_addr = 5'(i);
            @(negedge clk);
            check($sformatf("after_x0_x%0d", i), rs1, model[i]);
            check($sformatf("after_x0_same_x%0d", i), rs2, rs1);
            tick_run();
        end

        // Same-cycle write and read of x7 (old value 0).
        reg_wr = 1'b1; rd_addr = 5'd7; rd_data = 32'h12345678;
        rs1_addr = 5'd7; rs2_addr = 5'd1;
        @(negedge clk);
`ifdef REGFILE_BYPASS_EN
        check("x7_same_cycle", rs1, 32'h12345678);
`else
        check("x7_same_cycle", rs1, 32'h0);
`endif
        check("x7_other_port", rs2, 32'h0);
        tick_run();
        reg_wr = 1'b0; rs2_addr = 5'd7;
        @(negedge clk);
        check("x7_next_rs1", rs1, 32'h12345678);
        check("x7_next_rs2", rs2, 32'h12345678);
        tick_run();

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            reg_wr   = 1'($urandom);
            rd_addr  = 5'($urandom);
            rd_data  = $urandom;
            rs1_addr = ($urandom_range(0, 3) == 0) ? rd_addr : 5'($urandom);
            rs2_addr = ($urandom_range(0, 3) == 0) ? rs1_addr : 5'($urandom);
            @(negedge clk);
            check("rand_rs1", rs1, exp_rd(rs1_addr));
            check("rand_rs2", rs2, exp_rd(rs2_addr));
            check("rand_busy", {31'h0, busy}, 32'h0);
            tick_run();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
